// File: rtl/cdc_req_ack_arbiter.sv
// Source-side controller for one 4-phase req/ack CDC channel: round-robin arbitration
// of two requesters, registered payload held stable under CDC_REQ, and timeout abort.
module cdc_req_ack_arbiter #(
   parameter int BUS_WIDTH      = 8,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_WIDTH      = 7
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [BUS_WIDTH-1:0] SRC0_DATA,
   input  logic                 SRC0_VALID,
   output logic                 SRC0_READY,
   input  logic [BUS_WIDTH-1:0] SRC1_DATA,
   input  logic                 SRC1_VALID,
   output logic                 SRC1_READY,
   input  logic                 ACK_SYNC,
   output logic [BUS_WIDTH-1:0] CDC_DATA,
   output logic                 CDC_SRC,
   output logic                 CDC_REQ,
   output logic                 DONE,
   output logic                 TIMEOUT_ERR
);

   typedef enum logic [1:0] {IDLE, WAIT_ACK_HI, WAIT_ACK_LO, DRAIN} state_t;

   localparam logic [CNT_WIDTH-1:0] COUNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

   state_t               state;
   logic [CNT_WIDTH-1:0] count;
   logic                 last_src;
   logic                 grant0;
   logic                 grant1;
   logic                 open;
   logic                 expired;

   // A lone valid requester wins; on contention the one not served last wins.
   assign grant0  = SRC0_VALID & (~SRC1_VALID | last_src);
   assign grant1  = SRC1_VALID & (~SRC0_VALID | ~last_src);

   // A stale acknowledge still high from an aborted transfer blocks new acceptances.
   assign open    = (state == IDLE) & ~ACK_SYNC;
   assign expired = (count == COUNT_LAST);

   assign SRC0_READY = open & grant0;
   assign SRC1_READY = open & grant1;

   // NOTE: every register below uses non-blocking assignment so all of them update
   // from the same pre-edge values, regardless of statement order.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state       <= IDLE;
         count       <= '0;
         last_src    <= 1'b1;
         CDC_DATA    <= '0;
         CDC_SRC     <= 1'b0;
         CDC_REQ     <= 1'b0;
         DONE        <= 1'b0;
         TIMEOUT_ERR <= 1'b0;
      end else begin
         DONE        <= 1'b0;
         TIMEOUT_ERR <= 1'b0;
         case (state)
            IDLE: begin
               if (SRC0_READY || SRC1_READY) begin
                  CDC_DATA <= SRC1_READY ? SRC1_DATA : SRC0_DATA;
                  CDC_SRC  <= SRC1_READY;
                  last_src <= SRC1_READY;
                  CDC_REQ  <= 1'b1;
                  count    <= '0;
                  state    <= WAIT_ACK_HI;
               end
            end
            WAIT_ACK_HI: begin
               // An acknowledge on the expiry edge still completes the handshake.
               if (ACK_SYNC) begin
                  CDC_REQ <= 1'b0;
                  count   <= '0;
                  state   <= WAIT_ACK_LO;
               end else if (expired) begin
                  CDC_REQ     <= 1'b0;
                  TIMEOUT_ERR <= 1'b1;
                  state       <= DRAIN;
               end else begin
                  count <= count + CNT_WIDTH'(1);
               end
            end
            WAIT_ACK_LO: begin
               if (!ACK_SYNC) begin
                  DONE  <= 1'b1;
                  state <= IDLE;
               end else if (expired) begin
                  TIMEOUT_ERR <= 1'b1;
                  state       <= DRAIN;
               end else begin
                  count <= count + CNT_WIDTH'(1);
               end
            end
            DRAIN: begin
               if (!ACK_SYNC) begin
                  state <= IDLE;
               end
            end
         endcase
      end
   end

endmodule
